cmp_sort_engine: RTL and testbench

- Downstream/upstream neighbour of the 4-bit signed comparator (flags c1 = a>b, c2 = a==b, c3 = a<b).
- Accepts N signed words over a valid/ready stream and bubble-sorts them ascending by driving an external comparator and consuming its three flags.
- Streams the sorted words back out.
- Sits between the operand source and any consumer needing ordered data; the comparator is instantiated beside it at the next level up.

---
 rtl/cmp_sort_engine.sv | 145 ++++++++++++++
 tb/tb_cmp_sort_engine.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_sort_engine.sv
// cmp_sort_engine: loads N signed words, bubble-sorts them with an external
// comparator, streams them back out. Define SORT_DESCEND_EN for descending order.
module cmp_sort_engine #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] cmp_a,
    output logic [W-1:0] cmp_b,
    input  logic         cmp_gt,
    input  logic         cmp_eq,
    input  logic         cmp_lt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic [$clog2(N*(N-1)/2+1)-1:0] swap_cnt,
    output logic         cmp_err
);
    localparam int CW = $clog2(N*(N-1)/2+1);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N-1);

    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

    state_t        state, state_n;
    logic [W-1:0]  mem [N];
    logic [IW-1:0] idx, oidx, j, j1, limit;
    logic          swapped;
    logic [W-1:0]  hold_a, hold_b;
    logic          acc, take, onehot, sel, doswap, pass_end, done;

    // handshake qualifiers and compare decisions
    always_comb begin
        acc      = in_valid && (state == LOAD);
        take     = out_ready && (state == OUT);
        j1       = j + 1'b1;
        onehot   = ({cmp_gt, cmp_eq, cmp_lt} == 3'b100) ||
                   ({cmp_gt, cmp_eq, cmp_lt} == 3'b010) ||
                   ({cmp_gt, cmp_eq, cmp_lt} == 3'b001);
`ifdef SORT_DESCEND_EN
        sel      = cmp_lt;
`else
        sel      = cmp_gt;
`endif
        doswap   = (state == SORT) && onehot && sel;
        pass_end = (j == limit - 1'b1);
        done     = pass_end && (!(swapped || doswap) || limit == 1);
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    // next state
    always_comb begin
        state_n = state;
        unique case (state)
            LOAD: if (acc && idx == LAST) state_n = SORT;
            SORT: if (done) state_n = OUT;
            OUT:  if (take && oidx == LAST) state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end

    // stream and comparator outputs; operands hold outside SORT
    always_comb begin
        in_ready  = (state == LOAD);
        busy      = (state != LOAD);
        out_valid = (state == OUT);
        out_data  = mem[oidx];
        out_last  = (state == OUT) && (oidx == LAST);
        cmp_a     = (state == SORT) ? mem[j]  : hold_a;
        cmp_b     = (state == SORT) ? mem[j1] : hold_b;
    end

    // word buffer: load writes and compare swaps
    always_ff @(posedge clk) begin
        if (acc) begin
            mem[idx] <= in_data;
        end else if (doswap) begin
            mem[j]  <= mem[j1];
            mem[j1] <= mem[j];
        end
    end

    // indices, pass control, counters and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            oidx     <= '0;
            j        <= '0;
            limit    <= LAST;
            swapped  <= 1'b0;
            swap_cnt <= '0;
            cmp_err  <= 1'b0;
            hold_a   <= '0;
            hold_b   <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    oidx <= '0;
                    if (acc) begin
                        idx <= (idx == LAST) ? '0 : idx + 1'b1;
                        if (idx == LAST) begin
                            j        <= '0;
                            limit    <= LAST;
                            swapped  <= 1'b0;
                            swap_cnt <= '0;
                        end
                    end
                end
                SORT: begin
                    hold_a <= mem[j];
                    hold_b <= mem[j1];
                    if (!onehot) cmp_err <= 1'b1;
                    if (doswap) swap_cnt <= swap_cnt + CW'(1);
                    if (pass_end) begin
                        if (done) begin
                            oidx <= '0;
                        end else begin
                            limit   <= limit - 1'b1;
                            j       <= '0;
                            swapped <= 1'b0;
                        end
                    end else begin
                        j       <= j + 1'b1;
                        swapped <= swapped || doswap;
                    end
                end
                OUT: begin
                    if (take) oidx <= (oidx == LAST) ? '0 : oidx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_sort_engine.sv
// tb_cmp_sort_engine: scoreboard bench with a behavioural comparator,
// fault injection on one compare, output back-pressure and mid-job reset.
module tb_cmp_sort_engine;
    localparam int W = 4;
    localparam int N = 4;
    localparam int CW = $clog2(N*(N-1)/2+1);

    typedef logic signed [W-1:0] vec_t [N];

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [W-1:0]  cmp_a, cmp_b;
    logic          cmp_gt, cmp_eq, cmp_lt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic [CW-1:0] swap_cnt;
    logic          cmp_err;

    int errs = 0;
    int checks = 0;
    int ccnt = 0;
    int inj_k = -1;
    int m_cyc, m_swp, m_eq;
    int exp_err = 0;
    logic signed [W-1:0] exp_q [$];

    cmp_sort_engine #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .swap_cnt(swap_cnt), .cmp_err(cmp_err)
    );

    always #5 clk = ~clk;

    // comparator beside the engine, optionally faulted on compare inj_k
    always_comb begin
        cmp_gt = $signed(cmp_a) > $signed(cmp_b);
        cmp_eq = $signed(cmp_a) == $signed(cmp_b);
        cmp_lt = $signed(cmp_a) < $signed(cmp_b);
        if (busy && !out_valid && ccnt == inj_k) begin
            cmp_gt = 1'b1;
            cmp_eq = 1'b1;
            cmp_lt = 1'b0;
        end
    end

    // compare-cycle index within the current job
    always @(posedge clk) ccnt <= (busy && !out_valid) ? ccnt + 1 : 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // reference bubble sort; pushes expected words to the scoreboard
    task automatic model(input vec_t d, input int k);
        vec_t a;
        logic signed [W-1:0] t;
        int lim, jj;
        bit sw, g, e, l, ds;
        a = d; lim = N - 1; jj = 0; sw = 0;
        m_cyc = 0; m_swp = 0; m_eq = 0;
        for (int it = 0; it < 64; it++) begin
            g = a[jj] > a[jj+1];
            e = a[jj] == a[jj+1];
            l = a[jj] < a[jj+1];
            if (m_cyc == k) begin
                g = 1; e = 1; l = 0; exp_err = 1;
            end
            m_cyc++;
            if (e) m_eq++;
`ifdef SORT_DESCEND_EN
            ds = (int'(g) + int'(e) + int'(l) == 1) && l;
`else
            ds = (int'(g) + int'(e) + int'(l) == 1) && g;
`endif
            if (ds) begin
                t = a[jj]; a[jj] = a[jj+1]; a[jj+1] = t;
                sw = 1; m_swp++;
            end
            if (jj == lim - 1) begin
                if (!sw || lim == 1) break;
                lim--; jj = 0; sw = 0;
            end else begin
                jj++;
            end
        end
        for (int i = 0; i < N; i++) exp_q.push_back(a[i]);
    endtask

    task automatic load(input vec_t d);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = d[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_job(input string tag, input vec_t d,
                           input int k, input int hold_at);
        int sc, eqc;
        logic signed [W-1:0] e, held;
        model(d, k);
        inj_k = k;
        load(d);
        sc = 0; eqc = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (out_valid) break;
            if (busy) begin
                sc++;
                if (cmp_eq) eqc++;
            end
        end
        chk({tag, " out_valid"}, int'(out_valid), 1);
        chk({tag, " sort_cycles"}, sc, m_cyc);
        chk({tag, " swap_cnt"}, int'(swap_cnt), m_swp);
        chk({tag, " eq_cycles"}, eqc, m_eq);
        for (int i = 0; i < N; i++) begin
            if (i == hold_at) begin
                out_ready = 1'b0;
                held = $signed(out_data);
                repeat (5) begin
                    @(negedge clk);
                    chk({tag, " hold_valid"}, int'(out_valid), 1);
                    chk({tag, " hold_data"}, int'($signed(out_data)), int'(held));
                end
                out_ready = 1'b1;
            end
            if (exp_q.size() == 0) begin
                chk({tag, " queue"}, 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk({tag, " data"}, int'($signed(out_data)), int'(e));
            end
            chk({tag, " last"}, int'(out_last), int'(i == N - 1));
            @(negedge clk);
        end
        chk({tag, " in_ready_after"}, int'(in_ready), 1);
        chk({tag, " out_valid_after"}, int'(out_valid), 0);
        chk({tag, " cmp_err"}, int'(cmp_err), exp_err);
        inj_k = -1;
        @(posedge clk); #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " in_ready"}, int'(in_ready), 1);
        chk({tag, " out_valid"}, int'(out_valid), 0);
        chk({tag, " out_last"}, int'(out_last), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " swap_cnt"}, int'(swap_cnt), 0);
        chk({tag, " cmp_err"}, int'(cmp_err), 0);
        chk({tag, " cmp_a"}, int'(cmp_a), 0);
        chk({tag, " cmp_b"}, int'(cmp_b), 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst0");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        run_job("sorted", '{4'sh8, 4'shB, 4'sh2, 4'sh7}, -1, -1);
        run_job("reverse", '{4'sh7, 4'sh2, 4'shB, 4'sh8}, -1, -1);
        run_job("dups", '{4'sh3, 4'shF, 4'sh3, 4'shF}, -1, -1);
        run_job("hold", '{4'sh1, 4'shD, 4'sh6, 4'sh0}, -1, 1);

        load('{4'sh7, 4'sh2, 4'shB, 4'sh8});
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        run_job("fresh", '{4'sh5, 4'shA, 4'sh0, 4'sh1}, -1, -1);

        run_job("inject", '{4'sh7, 4'sh2, 4'shB, 4'sh8}, 0, -1);
        run_job("sticky", '{4'sh2, 4'sh1, 4'sh0, 4'shF}, -1, -1);
        rst = 1'b1;
        #1;
        chk("err_clear", int'(cmp_err), 0);
        exp_err = 0;
        @(negedge clk) rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
